// File: rtl/rand_gen_pkg.sv
// rand_gen_pkg: shared FSM states and LFSR helpers for constrained_rand_gen
package rand_gen_pkg;
  typedef enum logic [1:0] {IDLE, DRAW, RESP} state_e;
  function automatic logic [31:0] lfsr_mask(input int width);
    return width == 8 ? 32'hB8 : width == 16 ? 32'hB400 : 32'hA3000000;
  endfunction
  function automatic int tries_w(input int max_tries);
    return $clog2(max_tries + 1);
  endfunction
endpackage

// File: rtl/galois_lfsr.sv
// galois_lfsr: right-shift Galois LFSR with load and step, exposing the next value combinationally
module galois_lfsr #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] MASK = 'hA3000000,
  parameter logic [WIDTH-1:0] SEED = 'hACE12345
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             step,
  output logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] next
);
  always_comb next = state[0] ? (state >> 1) ^ MASK : state >> 1;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= SEED;
    else if (load) state <= load_value;
    else if (step) state <= next;
endmodule

// File: rtl/constrained_rand_gen.sv
// constrained_rand_gen: randomize() with {v > LOWER_BOUND;} via LFSR rejection sampling
module constrained_rand_gen
  import rand_gen_pkg::*;
#(
  parameter int              WIDTH       = 32,
  parameter longint unsigned LOWER_BOUND = 5,
  parameter int              MAX_TRIES   = 16,
  parameter logic [31:0]     SEED        = 32'hACE12345
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           seed_load,
  input  logic [WIDTH-1:0]               seed_value,
  input  logic                           req_valid,
  output logic                           req_ready,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [WIDTH-1:0]               rsp_value,
  output logic                           rsp_success,
  output logic [tries_w(MAX_TRIES)-1:0]  rsp_tries
);
  localparam logic [WIDTH-1:0] SEED_W = SEED[WIDTH-1:0];
  localparam logic [WIDTH-1:0] LB = WIDTH'(LOWER_BOUND);
  if (LOWER_BOUND >= (64'd1 << WIDTH) - 64'd1 || SEED_W == '0 || MAX_TRIES < 1 ||
      !(WIDTH == 8 || WIDTH == 16 || WIDTH == 32)) begin : g_bad_params
    $error("constrained_rand_gen: unsatisfiable or unsupported parameters");
  end
  state_e state, state_n;
  logic [WIDTH-1:0] lfsr_unused, lfsr_next;
  logic accept_draw, give_up;
  galois_lfsr #(.WIDTH(WIDTH), .MASK(WIDTH'(lfsr_mask(WIDTH))), .SEED(SEED_W)) u_lfsr (
    .clk(clk),
    .rst(rst),
    .load(state == IDLE && seed_load),
    .load_value(seed_value == '0 ? SEED_W : seed_value),
    .step(state == DRAW),
    .state(lfsr_unused),
    .next(lfsr_next)
  );
  assign accept_draw = lfsr_next > LB;
  assign give_up     = int'(rsp_tries) + 1 == MAX_TRIES;
  assign req_ready   = state == IDLE;
  assign rsp_valid   = state == RESP;
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (req_valid ? DRAW : IDLE)
            : state == DRAW ? (accept_draw || give_up ? RESP : DRAW)
            : (rsp_ready ? IDLE : RESP);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rsp_value   <= '0;
      rsp_success <= 1'b0;
      rsp_tries   <= '0;
    end else if (state == IDLE && req_valid) begin
      rsp_tries <= '0;
    end else if (state == DRAW) begin
      rsp_tries <= rsp_tries + 1'b1;
      if (accept_draw) begin
        rsp_value   <= lfsr_next;
        rsp_success <= 1'b1;
      end else if (give_up) begin
        rsp_success <= 1'b0;
      end
    end
endmodule

// File: tb/tb_constrained_rand_gen.sv
// tb_constrained_rand_gen: two WIDTH=8 instances (easy and near-unsatisfiable bound) against a request-level model
module tb_constrained_rand_gen;
  typedef struct packed {
    logic [7:0] lfsr;
    logic [7:0] val;
    logic       succ;
    logic [4:0] n;
  } outcome_t;
  logic clk = 1'b0, rst = 1'b1, seed_load = 1'b0, req_valid = 1'b0, rsp_ready = 1'b1;
  logic [7:0] seed_value = '0;
  logic       rdy[2], vld[2], succ[2];
  logic [7:0] val[2];
  logic [4:0] tries_a, tries[2];
  logic [1:0] tries_b;
  int n_chk = 0, n_fail = 0;
  int lb_p[2] = '{5, 'hFD};
  int mt_p[2] = '{16, 2};
  always #5 clk = ~clk;
  assign tries[0] = tries_a;
  assign tries[1] = {3'b000, tries_b};
  constrained_rand_gen #(.WIDTH(8), .LOWER_BOUND(5), .MAX_TRIES(16), .SEED(32'hACE12345)) dut_a (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed_value(seed_value),
    .req_valid(req_valid), .req_ready(rdy[0]), .rsp_valid(vld[0]), .rsp_ready(rsp_ready),
    .rsp_value(val[0]), .rsp_success(succ[0]), .rsp_tries(tries_a)
  );
  constrained_rand_gen #(.WIDTH(8), .LOWER_BOUND('hFD), .MAX_TRIES(2), .SEED(32'hACE12345)) dut_b (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed_value(seed_value),
    .req_valid(req_valid), .req_ready(rdy[1]), .rsp_valid(vld[1]), .rsp_ready(rsp_ready),
    .rsp_value(val[1]), .rsp_success(succ[1]), .rsp_tries(tries_b)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // Whole request resolved at once: walk the LFSR sequence until the bound is beaten or tries run out
  function automatic outcome_t run_req(logic [7:0] s, int lb, int mt);
    outcome_t o = '0;
    for (int k = 1; k <= mt && !o.succ; k++) begin
      s = s[0] ? (s >> 1) ^ 8'hB8 : s >> 1;
      o.n = 5'(k);
      if (int'(s) > lb) begin
        o.succ = 1'b1;
        o.val  = s;
      end
    end
    o.lfsr = s;
    return o;
  endfunction
  logic [7:0] m_lfsr[2], m_val[2], eff[2];
  logic       m_resp[2], m_succ[2];
  logic [4:0] m_tries[2];
  int         m_wait[2];
  outcome_t   pend[2], outc[2];
  always_comb
    for (int i = 0; i < 2; i++) begin
      eff[i]  = seed_load ? (seed_value == 8'h00 ? 8'h45 : seed_value) : m_lfsr[i];
      outc[i] = run_req(eff[i], lb_p[i], mt_p[i]);
    end
  always @(posedge clk or posedge rst)
    for (int i = 0; i < 2; i++)
      if (rst) begin
        m_lfsr[i] <= 8'h45; m_wait[i] <= 0; m_resp[i] <= 1'b0;
        m_val[i] <= '0; m_succ[i] <= 1'b0; m_tries[i] <= '0;
      end else if (m_resp[i]) begin
        if (rsp_ready) m_resp[i] <= 1'b0;
      end else if (m_wait[i] > 0) begin
        m_wait[i] <= m_wait[i] - 1;
        if (m_wait[i] == 1) begin
          m_resp[i]  <= 1'b1;
          m_succ[i]  <= pend[i].succ;
          m_tries[i] <= pend[i].n;
          if (pend[i].succ) m_val[i] <= pend[i].val;
        end
      end else if (req_valid) begin
        pend[i]   <= outc[i];
        m_wait[i] <= int'(outc[i].n);
        m_lfsr[i] <= outc[i].lfsr;
      end else begin
        m_lfsr[i] <= eff[i];
      end
  always @(negedge clk)
    if (!rst)
      for (int i = 0; i < 2; i++) begin
        check($sformatf("model_req_ready%0d", i), 32'(rdy[i]), 32'(!(m_resp[i] || m_wait[i] > 0)));
        check($sformatf("model_rsp_valid%0d", i), 32'(vld[i]), 32'(m_resp[i]));
        check($sformatf("model_rsp_value%0d", i), 32'(val[i]), 32'(m_val[i]));
        check($sformatf("model_rsp_success%0d", i), 32'(succ[i]), 32'(m_succ[i]));
        if (m_resp[i]) check($sformatf("model_rsp_tries%0d", i), 32'(tries[i]), 32'(m_tries[i]));
      end
  initial begin
    repeat (2) @(negedge clk);
    check("reset_req_ready", 32'(rdy[0]), 1);
    check("reset_rsp_valid", 32'(vld[0]), 0);
    check("reset_rsp_value", 32'(val[0]), 0);
    rst = 1'b0; seed_load = 1'b1; seed_value = 8'h01;
    @(negedge clk); seed_load = 1'b0; req_valid = 1'b1;
    @(negedge clk); req_valid = 1'b0;
    check("draw_req_ready", 32'(rdy[0]), 0);
    check("draw_rsp_valid", 32'(vld[0]), 0);
    @(negedge clk);
    check("first_valid", 32'(vld[0]), 1);
    check("first_value", 32'(val[0]), 'hB8);
    check("first_success", 32'(succ[0]), 1);
    check("first_tries", 32'(tries[0]), 1);
    @(negedge clk);
    check("fail_valid", 32'(vld[1]), 1);
    check("fail_value", 32'(val[1]), 0);
    check("fail_success", 32'(succ[1]), 0);
    check("fail_tries", 32'(tries[1]), 2);
    check("idle_after_rsp", 32'(rdy[0]), 1);
    @(negedge clk); req_valid = 1'b1;
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk);
    check("persist_value", 32'(val[0]), 'h5C);
    check("persist_tries", 32'(tries[0]), 1);
    @(negedge clk);
    check("persist_fail_success", 32'(succ[1]), 0);
    @(negedge clk); rsp_ready = 1'b0; seed_load = 1'b1; seed_value = 8'h01; req_valid = 1'b1;
    @(negedge clk); seed_load = 1'b0; req_valid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("bp_valid", 32'(vld[0]), 1);
      check("bp_value", 32'(val[0]), 'hB8);
      check("bp_req_ready", 32'(rdy[0]), 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_a", 32'(rdy[0]), 1);
    check("bp_release_b", 32'(rdy[1]), 1);
    seed_load = 1'b1; seed_value = 8'h00; req_valid = 1'b1;
    @(negedge clk); req_valid = 1'b0; seed_value = 8'h01;
    @(negedge clk); seed_load = 1'b0;
    check("zero_seed_value", 32'(val[0]), 'h9A);
    repeat (2) @(negedge clk);
    req_valid = 1'b1;
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk);
    check("draw_seed_ignored", 32'(val[0]), 'h4D);
    @(negedge clk); rsp_ready = 1'b0; req_valid = 1'b1;
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk);
    check("pre_reset_value", 32'(val[0]), 'h9E);
    #2 rst = 1'b1;
    #1;
    check("async_rst_req_ready", 32'(rdy[0]), 1);
    check("async_rst_rsp_valid", 32'(vld[0]), 0);
    check("async_rst_value", 32'(val[0]), 0);
    check("async_rst_success", 32'(succ[0]), 0);
    check("async_rst_tries", 32'(tries[0]), 0);
    check("async_rst_b_ready", 32'(rdy[1]), 1);
    @(negedge clk); rst = 1'b0; rsp_ready = 1'b1; req_valid = 1'b1;
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk);
    check("post_reset_seed_value", 32'(val[0]), 'h9A);
    check("post_reset_tries", 32'(tries[0]), 1);
    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
